// File: rtl/spi_fpga_sync_slave.sv
// spi_fpga_sync_slave: SPI responder oversampled by IN_CLOCK.
// SCLK/CS/MOSI are synchronized; received words land in IN_CLOCK domain.
//
// Ports:
//   IN_CLOCK, IN_RESET        system clock, sync active-high reset
//   IN_TRANSMIT_DATA          word for MISO, latched at frame start
//   IN_SCLK, IN_CS, IN_MOSI   asynchronous SPI inputs (CS active low)
//   OUT_MISO, OUT_MISO_OE     slave data and pad drive enable
//   OUT_RECEIVE_DATA/VALID    last complete word, 1-cycle update strobe
//   OUT_BUSY                  high while a frame is active
//   OUT_FRAME_ERROR           only with SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN:
//                             pulses when CS rises mid-word
module spi_fpga_sync_slave #(
  parameter int   PACK_LENGTH                = 8,
  parameter logic CPOL                       = 1'b1,
  parameter logic CPHA                       = 1'b0,
  parameter int   PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int   PACK_BIT_SEQUENCE_RECEIVE  = 0
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET,
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   IN_SCLK,
  input  logic                   IN_CS,
  input  logic                   IN_MOSI,
  output logic                   OUT_MISO,
  output logic                   OUT_MISO_OE,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic                   OUT_RECEIVE_VALID,
  output logic                   OUT_BUSY
`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
  ,
  output logic                   OUT_FRAME_ERROR
`endif
);

  localparam int CW = $clog2(PACK_LENGTH + 1);
  localparam int IW = $clog2(PACK_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(PACK_LENGTH - 1);
  localparam logic [CW-1:0] FULL = CW'(PACK_LENGTH);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1, r_cs_s2, r_cs_prev;
  logic r_mosi_s1, r_mosi_s2;
  logic [1:0] r_fill;

  logic [PACK_LENGTH-1:0] r_tx;
  logic [PACK_LENGTH-1:0] r_rx;
  logic [PACK_LENGTH-1:0] r_rdata;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_tx_cnt;
  logic r_miso, r_oe, r_valid;

  logic w_rise, w_fall, w_lead, w_trail;
  logic w_active, w_sample, w_shift, w_cs_fall;
  logic w_done, w_new_first;
  logic [IW-1:0] w_rx_idx;
  logic [IW-1:0] w_tx_idx;
  logic [PACK_LENGTH-1:0] w_rx_word;

  // r_fill marks when the sync chain holds real samples rather than
  // reset values, so a frame already running at reset release is not
  // mistaken for a fresh CS falling edge.
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_s3 <= CPOL;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_prev <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_fill    <= 2'b00;
    end else begin
      r_sclk_s1 <= IN_SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= IN_CS;
      r_cs_s2   <= r_cs_s1;
      r_cs_prev <= r_fill[1] ? r_cs_s2 : 1'b0;
      r_mosi_s1 <= IN_MOSI;
      r_mosi_s2 <= r_mosi_s1;
      r_fill    <= {r_fill[0], 1'b1};
    end
  end

  assign w_rise    = r_sclk_s2 & ~r_sclk_s3;
  assign w_fall    = ~r_sclk_s2 & r_sclk_s3;
  assign w_lead    = CPOL ? w_fall : w_rise;
  assign w_trail   = CPOL ? w_rise : w_fall;
  assign w_active  = (r_state == S_ACTIVE);
  assign w_sample  = w_active & (CPHA ? w_trail : w_lead);
  assign w_shift   = w_active & (CPHA ? w_lead : w_trail);
  assign w_cs_fall = r_cs_prev & ~r_cs_s2;

  always_comb begin
    w_rx_idx = (PACK_BIT_SEQUENCE_RECEIVE != 0) ?
               IW'(LAST - r_cnt) : IW'(r_cnt);
    w_tx_idx = (PACK_BIT_SEQUENCE_TRANSMIT != 0) ?
               IW'(LAST - r_tx_cnt) : IW'(r_tx_cnt);
    w_new_first = (PACK_BIT_SEQUENCE_TRANSMIT != 0) ?
                  IN_TRANSMIT_DATA[PACK_LENGTH-1] :
                  IN_TRANSMIT_DATA[0];
    w_rx_word = r_rx;
    w_rx_word[w_rx_idx] = r_mosi_s2;
    w_done = w_sample && (r_cnt == LAST);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_cs_fall) w_state_next = S_ACTIVE;
      S_ACTIVE: if (r_cs_s2) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
  logic r_ferr;
  logic [CW-1:0] w_cnt_after;
  assign w_cnt_after = r_cnt + CW'(w_sample);
  assign OUT_FRAME_ERROR = r_ferr;

  // A final sample coinciding with CS release completes the word.
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) r_ferr <= 1'b0;
    else r_ferr <= w_active && r_cs_s2 && !w_done &&
                   (w_cnt_after != '0);
  end
`endif

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_tx     <= '0;
      r_rx     <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_tx_cnt <= '0;
      r_miso   <= 1'b0;
      r_oe     <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_sample) begin
        r_rx  <= w_rx_word;
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        if (w_done) begin
          r_rdata <= w_rx_word;
          r_valid <= 1'b1;
        end
      end
      // Once a full word has been presented, the next shift edge starts
      // a fresh word so frames can run back-to-back under one CS.
      if (w_shift) begin
        if (r_tx_cnt == FULL) begin
          r_tx     <= IN_TRANSMIT_DATA;
          r_miso   <= w_new_first;
          r_tx_cnt <= CW'(1);
        end else begin
          r_miso   <= r_tx[w_tx_idx];
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
      if (!w_active && w_cs_fall) begin
        r_tx  <= IN_TRANSMIT_DATA;
        r_rx  <= '0;
        r_cnt <= '0;
        r_oe  <= 1'b1;
        if (!CPHA) begin
          r_miso   <= w_new_first;
          r_tx_cnt <= CW'(1);
        end else begin
          r_miso   <= 1'b0;
          r_tx_cnt <= '0;
        end
      end
      if (w_active && r_cs_s2) begin
        r_oe     <= 1'b0;
        r_miso   <= 1'b0;
        r_cnt    <= '0;
        r_tx_cnt <= '0;
      end
    end
  end

  assign OUT_MISO          = r_miso;
  assign OUT_MISO_OE       = r_oe;
  assign OUT_RECEIVE_DATA  = r_rdata;
  assign OUT_RECEIVE_VALID = r_valid;
  assign OUT_BUSY          = w_active;

endmodule

// File: tb/tb_spi_fpga_sync_slave.sv
// tb_spi_fpga_sync_slave: five slaves (default config + all SPI modes
// with MSB-first receive) driven by a behavioural SPI master.
module tb_spi_fpga_sync_slave;

  localparam int N = 5;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst;
  logic sclk [N];
  logic cs   [N];
  logic mosi [N];
  logic miso [N];
  logic oe   [N];
  logic valid[N];
  logic busy [N];
  logic [L-1:0] txd  [N];
  logic [L-1:0] rdata[N];
  logic [L-1:0] last_rx[N];
`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
  logic ferr[N];
  int   fe_cnt[N];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] vq[$];

  always #10 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam logic POL = (g == 0) ? 1'b1 : ((g - 1) / 2 == 1);
    localparam logic PHA = (g == 0) ? 1'b0 : ((g - 1) % 2 == 1);
    localparam int   RXM = (g == 0) ? 0 : 1;
    spi_fpga_sync_slave #(
      .PACK_LENGTH(L),
      .CPOL(POL),
      .CPHA(PHA),
      .PACK_BIT_SEQUENCE_TRANSMIT(1),
      .PACK_BIT_SEQUENCE_RECEIVE(RXM)
    ) u_dut (
      .IN_CLOCK(clk),
      .IN_RESET(rst),
      .IN_TRANSMIT_DATA(txd[g]),
      .IN_SCLK(sclk[g]),
      .IN_CS(cs[g]),
      .IN_MOSI(mosi[g]),
      .OUT_MISO(miso[g]),
      .OUT_MISO_OE(oe[g]),
      .OUT_RECEIVE_DATA(rdata[g]),
      .OUT_RECEIVE_VALID(valid[g]),
      .OUT_BUSY(busy[g])
`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
      ,
      .OUT_FRAME_ERROR(ferr[g])
`endif
    );
  end

  function automatic logic pol_of(int k);
    return (k == 0) ? 1'b1 : ((k - 1) / 2 == 1);
  endfunction

  function automatic bit pha_of(int k);
    return (k == 0) ? 1'b0 : ((k - 1) % 2 == 1);
  endfunction

  // Word the slave should assemble from bits mb[off..off+7] in
  // arrival order: LSB-first for instance 0, MSB-first otherwise.
  function automatic logic [7:0] model_rx(int k, logic [15:0] mb,
                                          int off);
    int v = 0;
    for (int i = 0; i < 8; i++)
      if (mb[off+i]) v += (k != 0) ? (1 << (7 - i)) : (1 << i);
    return 8'(v);
  endfunction

  // Master receives MSB-first.
  function automatic logic [7:0] master_word(logic [15:0] rb, int off);
    int v = 0;
    for (int i = 0; i < 8; i++)
      if (rb[off+i]) v += 1 << (7 - i);
    return 8'(v);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (valid[k] === 1'b1) vq.push_back({4'(k), rdata[k]});
`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
      if (ferr[k] === 1'b1) fe_cnt[k]++;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input int k, input int n, input logic [15:0] mb,
                      input bit chg, input logic [7:0] tx2,
                      output logic [15:0] rb);
    logic pol;
    bit   pha;
    pol = pol_of(k);
    pha = pha_of(k);
    rb = '0;
    cs[k] = 1'b0;
    if (!pha) mosi[k] = mb[0];
    half();
    chk("oe_on", oe[k], 1);
    chk("busy_on", busy[k], 1);
    for (int i = 0; i < n; i++) begin
      sclk[k] = ~pol;
      if (pha) mosi[k] = mb[i];
      else     rb[i] = miso[k];
      if (!pha && chg && i == 7) begin
        repeat (5) @(negedge clk);
        txd[k] = tx2;
        repeat (3) @(negedge clk);
      end else half();
      sclk[k] = pol;
      if (pha) rb[i] = miso[k];
      else if (i + 1 < n) mosi[k] = mb[i+1];
      if (pha && chg && i == 7) begin
        repeat (5) @(negedge clk);
        txd[k] = tx2;
        repeat (3) @(negedge clk);
      end else half();
    end
    cs[k] = 1'b1;
    half();
  endtask

  task automatic expect_rx(input int k, input int n,
                           input logic [7:0] e0, input logic [7:0] e1);
    logic [11:0] e;
    chk("valid_cnt", vq.size(), n);
    for (int i = 0; i < n && vq.size() > 0; i++) begin
      e = vq.pop_front();
      chk("rx_word", e, {4'(k), (i == 0) ? e0 : e1});
    end
    vq.delete();
  endtask

  task automatic frame(input int k, input logic [7:0] w,
                       input bit mmsb, input logic [7:0] t);
    logic [15:0] mb, rb;
    logic [7:0]  er;
    mb = '0;
    for (int i = 0; i < 8; i++) mb[i] = mmsb ? w[7-i] : w[i];
    txd[k] = t;
    @(negedge clk);
    xfer(k, 8, mb, 1'b0, 8'h00, rb);
    er = model_rx(k, mb, 0);
    expect_rx(k, 1, er, 8'h00);
    chk("rdata_hold", rdata[k], er);
    chk("master_rx", master_word(rb, 0), t);
    chk("oe_off", oe[k], 0);
    chk("busy_off", busy[k], 0);
    last_rx[k] = er;
  endtask

  task automatic b2b(input int k, input logic [7:0] w1,
                     input logic [7:0] w2, input logic [7:0] t1,
                     input logic [7:0] t2);
    logic [15:0] mb, rb;
    for (int i = 0; i < 8; i++) begin
      mb[i]   = w1[7-i];
      mb[8+i] = w2[7-i];
    end
    txd[k] = t1;
    @(negedge clk);
    xfer(k, 16, mb, 1'b1, t2, rb);
    expect_rx(k, 2, model_rx(k, mb, 0), model_rx(k, mb, 8));
    chk("b2b_mrx0", master_word(rb, 0), t1);
    chk("b2b_mrx1", master_word(rb, 8), t2);
    last_rx[k] = model_rx(k, mb, 8);
  endtask

  task automatic abort5(input int k);
    logic [15:0] mb, rb;
`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
    int fe0;
    fe0 = fe_cnt[k];
`endif
    mb = 16'h00FF;
    txd[k] = 8'h96;
    @(negedge clk);
    xfer(k, 5, mb, 1'b0, 8'h00, rb);
    chk("abort_valid", vq.size(), 0);
    vq.delete();
    chk("abort_hold", rdata[k], last_rx[k]);
    chk("abort_oe", oe[k], 0);
    chk("abort_miso", miso[k], 0);
`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
    chk("frame_err", fe_cnt[k] - fe0, 1);
`endif
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      sclk[k] = pol_of(k);
      cs[k] = 1'b1;
      mosi[k] = 1'b0;
      txd[k] = '0;
      last_rx[k] = '0;
`ifdef SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN
      fe_cnt[k] = 0;
`endif
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < N; k++)
      chk("reset_out", {oe[k], miso[k], valid[k], busy[k], rdata[k]}, 0);

    frame(0, 8'hEA, 1'b0, 8'h53);
    for (int k = 1; k < N; k++) frame(k, 8'hA5, 1'b1, 8'h3C);

    b2b(0, 8'h12, 8'h34, 8'hF0, 8'h0F);
    b2b(2, 8'h12, 8'h34, 8'hF0, 8'h0F);

    abort5(0);
    abort5(2);

    repeat (12) begin
      frame($urandom_range(0, N - 1), 8'($urandom), 1'($urandom),
            8'($urandom));
    end

    // Reset in the middle of a frame on instance 0.
    txd[0] = 8'hC3;
    cs[0] = 1'b0;
    half();
    for (int i = 0; i < 3; i++) begin
      sclk[0] = 1'b0; half();
      sclk[0] = 1'b1; half();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", {oe[0], miso[0], valid[0], busy[0], rdata[0]}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk[0] = 1'b0; half();
      sclk[0] = 1'b1; half();
    end
    chk("stale_busy", busy[0], 0);
    cs[0] = 1'b1;
    half();
    chk("stale_valid", vq.size(), 0);
    vq.delete();
    chk("stale_rdata", rdata[0], 0);
    for (int k = 0; k < N; k++) last_rx[k] = '0;
    frame(0, 8'h5A, 1'b1, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_fpga_sync_slave.md
Name: spi_fpga_sync_slave

Overview:
- SPI responder clocked entirely by the system clock; oversamples SCLK/CS/MOSI instead of using SCLK as a clock.
- Counterpart to SPI_FPGA_MASTER for on-chip use where received data must land in the IN_CLOCK domain with a valid strobe.
- Supports all four CPOL/CPHA modes, configurable bit order, back-to-back frames within one CS assertion.

Parameters:
- PACK_LENGTH, 8, bits per frame (2..32).
- CPOL, 1'b1, SCLK idle level.
- CPHA, 1'b0, 0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing.
- PACK_BIT_SEQUENCE_TRANSMIT, 1, 1: MSB first on MISO; 0: LSB first.
- PACK_BIT_SEQUENCE_RECEIVE, 0, 1: first MOSI bit is MSB; 0: first bit is LSB.

Ports:
- IN_CLOCK  input  1  system clock.
- IN_RESET  input  1  synchronous, active-high reset.
- IN_TRANSMIT_DATA  input  PACK_LENGTH  word to send on MISO; latched at frame start.
- IN_SCLK  input  1  SPI clock from master (asynchronous).
- IN_CS  input  1  chip select, active low (asynchronous).
- IN_MOSI  input  1  master-out data (asynchronous).
- OUT_MISO  output  1  slave-out data.
- OUT_MISO_OE  output  1  MISO drive enable for the pad tristate.
- OUT_RECEIVE_DATA  output  PACK_LENGTH  last complete received word, held until the next completion.
- OUT_RECEIVE_VALID  output  1  one-cycle strobe when OUT_RECEIVE_DATA updates.
- OUT_BUSY  output  1  high while the block is in ACTIVE.

Behaviour:
- Synchronizers: IN_SCLK, IN_CS, IN_MOSI each pass through 2 flops, plus a third SCLK flop for edge detect. Reset values: CS sync = 1, SCLK sync = CPOL, MOSI sync = 0.
- Leading edge is rising when CPOL=0, falling when CPOL=1. Sample edge is leading when CPHA=0, trailing when CPHA=1. Shift edge is the other one.
- Constraint: SCLK high and low phases each ≥ 4 IN_CLOCK cycles. Faster SCLK is unsupported and not detected.
- Reset: OUT_MISO=0, OUT_MISO_OE=0, OUT_RECEIVE_DATA=0, OUT_RECEIVE_VALID=0, OUT_BUSY=0, state IDLE, counters 0.
- States:
  - IDLE → ACTIVE on synced CS falling. On that transition: latch IN_TRANSMIT_DATA into tx_reg, clear rx bit counter, set OUT_MISO_OE=1. When CPHA=0, also drive the first TX bit on OUT_MISO in the same cycle.
  - ACTIVE → IDLE on synced CS high, from any point in the frame.
- Sample edge (ACTIVE):
  - MOSI sync bit is placed in rx_reg at position count (LSB-first) or PACK_LENGTH-1-count (MSB-first); count increments.
  - When count reaches PACK_LENGTH: OUT_RECEIVE_DATA ← assembled word, OUT_RECEIVE_VALID=1 for exactly 1 cycle, count ← 0.
- MISO update (ACTIVE):
  - CPHA=0: next bit on each shift edge.
  - CPHA=1: bit on each shift (leading) edge, starting with the first bit.
  - After PACK_LENGTH bits have been presented, IN_TRANSMIT_DATA is re-latched. The next bit presented is the first bit of the new word, so back-to-back frames work without CS toggling.
- Latency: OUT_RECEIVE_VALID rises 3 IN_CLOCK cycles after the final sample edge reaches IN_SCLK.
- CS deassert mid-frame: partial rx discarded, no VALID pulse, OUT_RECEIVE_DATA unchanged, OUT_MISO_OE=0, OUT_MISO=0.
- CS deassert in the same cycle as the final sample edge: the frame counts as complete and VALID pulses.
- SCLK edges while CS is high: ignored.
- IN_RESET asserted mid-frame: the block returns to reset state next cycle. A frame already in progress when reset releases is ignored until CS goes high and falls again.
- OUT_BUSY = (state == ACTIVE).

Optional Feature:
- Macro: SPI_FPGA_SYNC_SLAVE_FRAME_ERROR_EN.
- Defined: adds output OUT_FRAME_ERROR (1 bit). It pulses high for 1 cycle when CS deasserts with 0 < count < PACK_LENGTH. Reset value 0.
- Undefined: the port and its logic are absent; mid-frame aborts are silent.

Test Plan:
- Setup for all cases: PACK_LENGTH=8, IN_CLOCK=50 MHz, SCLK=3.125 MHz, master from SPI_FPGA_MASTER.
- CPOL=1, CPHA=0, master TX LSB-first, slave RX LSB-first. Master sends 8'b11101010 and the slave transmits 8'b01010011 MSB-first → OUT_RECEIVE_DATA=8'hEA with one VALID pulse; master receives 8'h53 (MSB-first RX).
- Sweep all four CPOL/CPHA modes with master 8'hA5 and slave 8'h3C, both MSB-first → slave gets 8'hA5 and master gets 8'h3C in every mode.
- Back-to-back frames: CS held low for 16 SCLK. Master sends 8'h12 then 8'h34; slave IN_TRANSMIT_DATA changes 8'hF0→8'h0F between frames → two VALID pulses with data 8'h12, 8'h34; master receives 8'hF0, 8'h0F.
- Abort: CS raised after 5 bits of 8'hFF → no VALID pulse, OUT_RECEIVE_DATA keeps its previous value, OUT_MISO_OE=0. With FRAME_ERROR_EN defined, OUT_FRAME_ERROR pulses once.
- Reset: IN_RESET for 3 cycles mid-frame → all outputs 0 next cycle. A following full frame of 8'h5A is received correctly.
